// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte-stream
// requesters. A grant lasts for a whole packet (up to MAX_BURST bytes), and
// bytes are paced on the transmitter's busy flag. tx_start, tx_data and
// req_ready are registered, so the byte, its start pulse and its acceptance
// strobe all appear in the same cycle.
module uart_tx_arbiter #(
   parameter  int N_REQ     = 4,
   parameter  int DATA_W    = 8,
   parameter  int MAX_BURST = 16,
   localparam int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   input  logic [N_REQ-1:0]        req_last,
   output logic [N_REQ-1:0]        req_ready,
   output logic                    tx_start,
   output logic [DATA_W-1:0]       tx_data,
   input  logic                    tx_busy,
   output logic                    grant_valid,
   output logic [ID_W-1:0]         grant_id
);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      SEND,
      WAIT_DONE
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  scan_id;
   logic [ID_W-1:0]  sel_id;
   logic             sel_found;
   logic [CNT_W-1:0] burst_cnt;
   logic             last_q;
   logic             do_grant;
   logic             do_start;
   logic             do_release;

   // Round-robin search: first requesting index at or above rr_ptr, with wrap.
   // Scanning from the far end down lets the nearest hit overwrite the others.
   // NOTE: every signal written here gets a default before any branch, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      sel_found = 1'b0;
      sel_id    = rr_ptr;
      scan_id   = rr_ptr;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         scan_id = ID_W'((int'(rr_ptr) + k) % N_REQ);
         if (req_valid[scan_id]) begin
            sel_found = 1'b1;
            sel_id    = scan_id;
         end
      end
   end

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and the single-cycle action strobes for the datapath.
   always_comb begin
      state_next = state;
      do_grant   = 1'b0;
      do_start   = 1'b0;
      do_release = 1'b0;
      case (state)
         IDLE: begin
            if (sel_found) begin
               do_grant   = 1'b1;
               state_next = GRANT;
            end
         end
         GRANT: begin
            // The owner keeps the transmitter even while it stalls mid-packet.
            if (req_valid[grant_id] && !tx_busy) begin
               do_start   = 1'b1;
               state_next = SEND;
            end
         end
         SEND: begin
            // The transmitter raises busy the cycle after tx_start.
            if (tx_busy) begin
               state_next = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               if (last_q || (burst_cnt == CNT_W'(MAX_BURST))) begin
                  do_release = 1'b1;
                  state_next = IDLE;
               end else begin
                  state_next = GRANT;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Grant bookkeeping, byte capture and the registered transmitter interface.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr      <= '0;
         grant_valid <= 1'b0;
         grant_id    <= '0;
         burst_cnt   <= '0;
         last_q      <= 1'b0;
         tx_start    <= 1'b0;
         tx_data     <= '0;
         req_ready   <= '0;
      end else begin
         tx_start  <= do_start;
         req_ready <= do_start ? (N_REQ'(1) << grant_id) : '0;
         if (do_grant) begin
            grant_valid <= 1'b1;
            grant_id    <= sel_id;
            burst_cnt   <= '0;
         end
         if (do_start) begin
            tx_data   <= req_data[grant_id*DATA_W +: DATA_W];
            last_q    <= req_last[grant_id];
            burst_cnt <= burst_cnt + CNT_W'(1);
         end
         if (do_release) begin
            // The releasing requester drops to lowest priority.
            grant_valid <= 1'b0;
            rr_ptr      <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter. An environment process plays the
// transmitter (busy after each start) and the requesters (byte queues popped
// on req_ready), and scores every tx_start against an expected (id, byte)
// queue. Directed sequences cover the multi-cycle corners; a vector table
// covers arbitration priority; a packet-level model predicts random traffic.
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int MB = 16;

   typedef struct packed {
      logic [W-1:0] data;
      logic         last;
   } byte_t;

   typedef struct packed {
      logic [1:0]   id;
      logic [W-1:0] data;
   } exp_t;

   typedef struct {
      int           prev;
      logic [N-1:0] mask;
      int           exp_id;
   } arb_vec_t;

   logic           clk         = 1'b0;
   logic           reset       = 1'b1;
   logic [N-1:0]   req_valid   = '0;
   logic [N*W-1:0] req_data    = '0;
   logic [N-1:0]   req_last    = '0;
   logic [N-1:0]   req_ready;
   logic           tx_start;
   logic [W-1:0]   tx_data;
   logic           tx_busy     = 1'b0;
   logic           grant_valid;
   logic [1:0]     grant_id;

   int           total      = 0;
   int           bad        = 0;
   byte_t        rq[N][$];
   exp_t         exp_q[$];
   int           gap_q[$];
   logic [N-1:0] en         = '1;
   bit           free_run   = 1'b0;
   bit           rand_busy  = 1'b0;
   bit           rand_stall = 1'b0;
   bit           pend       = 1'b0;
   int           busy_len   = 3;
   int           busy_left  = 0;
   int           cyc        = 0;
   int           fall_cyc   = 0;
   int           n_start    = 0;
   logic [W-1:0] cur_data   = '0;

   uart_tx_arbiter #(
      .N_REQ    (N),
      .DATA_W   (W),
      .MAX_BURST(MB)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_last   (req_last),
      .req_ready  (req_ready),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .tx_busy    (tx_busy),
      .grant_valid(grant_valid),
      .grant_id   (grant_id)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
      end
   endtask

   function automatic logic [N-1:0] onehot(input logic [1:0] id);
      logic [N-1:0] v;
      v     = '0;
      v[id] = 1'b1;
      return v;
   endfunction

   function automatic int gap_at(input int k);
      if (k < gap_q.size()) return gap_q[k];
      return -1;
   endfunction

   function automatic bit rq_empty();
      for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic push_exp(input int id, input logic [W-1:0] d);
      exp_t e;
      e.id   = 2'(id);
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Queue an n-byte packet base, base+1, ... with last on the final byte.
   task automatic push_pkt(input int id, input int n, input logic [W-1:0] base, input bit add_exp);
      byte_t b;
      for (int k = 0; k < n; k++) begin
         b.data = base + W'(k);
         b.last = (k == n - 1);
         rq[id].push_back(b);
         if (add_exp) push_exp(id, b.data);
      end
   endtask

   task automatic wait_quiet(input string name, input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(posedge clk);
         #2;
         done = (exp_q.size() == 0) && !grant_valid && !tx_busy && !pend && rq_empty();
      end
      check(name, 32'(done), 1);
   endtask

   task automatic wait_starts(input string name, input int target, input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(posedge clk);
         #2;
         done = (n_start >= target);
      end
      check(name, 32'(done), 1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
   endtask

   // Environment: transmitter model, requester queues and start scoreboard.
   initial begin : env
      exp_t e;
      bit   gate;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (reset) begin
            tx_busy   = 1'b0;
            pend      = 1'b0;
            busy_left = 0;
         end else begin
            if (tx_busy) begin
               busy_left--;
               if (busy_left == 0) begin
                  tx_busy  = 1'b0;
                  fall_cyc = cyc;
               end
            end
            if (pend) begin
               tx_busy   = 1'b1;
               busy_left = rand_busy ? int'($urandom_range(1, 6)) : busy_len;
               pend      = 1'b0;
            end
            if (tx_busy && tx_data !== cur_data) check("tx_data_hold", tx_data, cur_data);
            if (tx_start) begin
               pend     = 1'b1;
               n_start++;
               gap_q.push_back(cyc - fall_cyc);
               cur_data = tx_data;
               check("start_ready", {grant_valid, req_ready}, {1'b1, onehot(grant_id)});
               if (!free_run) begin
                  check("start_expected", 32'(exp_q.size() > 0), 1);
                  if (exp_q.size() > 0) begin
                     e = exp_q.pop_front();
                     check("start_id", grant_id, e.id);
                     check("start_data", tx_data, e.data);
                  end
               end
            end else if (req_ready != '0) begin
               check("ready_without_start", req_ready, 0);
            end
            for (int i = 0; i < N; i++)
               if (req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
         end
         gate = rand_stall && ($urandom_range(0, 3) == 0);
         for (int i = 0; i < N; i++) begin
            req_valid[i] = en[i] && (rq[i].size() > 0) && !gate;
            if (rq[i].size() > 0) begin
               req_data[i*W +: W] = rq[i][0].data;
               req_last[i]        = rq[i][0].last;
            end
         end
      end
   end

   initial begin : main
      arb_vec_t vecs[8];
      byte_t    mq[N][$];
      byte_t    b;
      int       base;
      int       gid_err;
      int       mptr;
      int       sel;
      int       idx;
      int       cnt;
      bit       done;
      bit       more;

      // {previous owner, requesting set, expected first grant}
      vecs[0] = '{0, 4'b1111, 1};
      vecs[1] = '{1, 4'b0011, 0};
      vecs[2] = '{3, 4'b1000, 3};
      vecs[3] = '{2, 4'b1001, 3};
      vecs[4] = '{1, 4'b0110, 2};
      vecs[5] = '{3, 4'b0110, 1};
      vecs[6] = '{2, 4'b0100, 2};
      vecs[7] = '{0, 4'b1101, 2};

      repeat (3) @(posedge clk);
      #2;
      check("reset_outputs", {tx_start, req_ready, tx_data, grant_valid, grant_id}, 0);
      reset = 1'b0;

      // Round-robin from reset with one-byte packets: 0,1,2,3,0.
      busy_len = 3;
      gap_q.delete();
      push_pkt(0, 1, 8'hA0, 1'b1);
      push_pkt(1, 1, 8'hA1, 1'b1);
      push_pkt(2, 1, 8'hA2, 1'b1);
      push_pkt(3, 1, 8'hA3, 1'b1);
      push_pkt(0, 1, 8'hA4, 1'b1);
      wait_quiet("rr_quiet", 500);
      for (int k = 1; k < 5; k++) check("rr_packet_gap", gap_at(k), 3);

      // Priority table: one owner releases, then a set requests together.
      free_run = 1'b1;
      foreach (vecs[v]) begin
         push_pkt(vecs[v].prev, 1, 8'hC0, 1'b0);
         wait_quiet("arb_prev_quiet", 200);
         for (int i = 0; i < N; i++)
            if (vecs[v].mask[i]) push_pkt(i, 1, 8'(8'hD0 + i), 1'b0);
         for (int i = 0; i < 50 && !grant_valid; i++) begin
            @(posedge clk);
            #2;
         end
         check("arb_grant_seen", 32'(grant_valid), 1);
         check("arb_first_grant", grant_id, vecs[v].exp_id);
         wait_quiet("arb_quiet", 500);
      end
      free_run = 1'b0;

      // Single requester, 3-byte packet, 10-cycle busy.
      busy_len = 10;
      gap_q.delete();
      base     = n_start;
      gid_err  = 0;
      done     = 1'b0;
      push_pkt(2, 3, 8'h41, 1'b1);
      for (int i = 0; i < 400 && !done; i++) begin
         @(posedge clk);
         #2;
         if (grant_valid && grant_id != 2'd2) gid_err++;
         done = (n_start == base + 3) && !tx_busy && !pend;
      end
      check("single_last_fall_seen", 32'(done), 1);
      check("single_gid_stable", gid_err, 0);
      check("single_owner_until_fall", 32'(grant_valid), 1);
      @(posedge clk);
      #2;
      check("single_release", 32'(grant_valid), 0);
      check("single_start_count", n_start - base, 3);
      check("single_byte_gap1", gap_at(1), 2);
      check("single_byte_gap2", gap_at(2), 2);
      // Pointer now sits after 2: requester 3 outranks requester 0.
      busy_len = 3;
      push_pkt(3, 1, 8'hB3, 1'b1);
      push_pkt(0, 1, 8'hB0, 1'b1);
      wait_quiet("single_ptr_quiet", 300);

      // Packet atomicity: requester 0 arrives after requester 1's first byte.
      base = n_start;
      push_pkt(1, 4, 8'h10, 1'b1);
      wait_starts("atomic_first_byte", base + 1, 100);
      push_pkt(0, 1, 8'h50, 1'b1);
      wait_quiet("atomic_quiet", 500);

      // Burst limit: 20-byte packet is cut after 16, requester 0 slips in.
      busy_len = 2;
      push_pkt(3, 20, 8'h60, 1'b0);
      push_pkt(0, 1, 8'h55, 1'b0);
      for (int k = 0; k < 16; k++) push_exp(3, 8'(8'h60 + k));
      push_exp(0, 8'h55);
      for (int k = 16; k < 20; k++) push_exp(3, 8'(8'h60 + k));
      wait_quiet("burst_quiet", 2000);

      // Owner stall: requester 2 drops valid mid-packet, requester 1 waits.
      busy_len = 4;
      base     = n_start;
      push_pkt(2, 4, 8'h20, 1'b1);
      wait_starts("stall_first_byte", base + 1, 100);
      push_pkt(1, 1, 8'h31, 1'b1);
      wait_starts("stall_second_byte", base + 2, 100);
      en[2]   = 1'b0;
      gid_err = 0;
      repeat (50) begin
         @(posedge clk);
         #2;
         if (!grant_valid || grant_id != 2'd2) gid_err++;
      end
      check("stall_no_start", n_start - base, 2);
      check("stall_owner_kept", gid_err, 0);
      en[2] = 1'b1;
      wait_quiet("stall_quiet", 500);

      // Reset while waiting on requester 1's second byte.
      busy_len = 8;
      base     = n_start;
      push_pkt(1, 4, 8'h80, 1'b1);
      wait_starts("reset_second_byte", base + 2, 100);
      repeat (3) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("reset_async_outputs", {tx_start, req_ready, tx_data, grant_valid, grant_id}, 0);
      push_pkt(3, 1, 8'h93, 1'b1);
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      wait_quiet("reset_resume_quiet", 500);

      // Random packets, random busy lengths, random global valid gaps.
      do_reset();
      rand_busy  = 1'b1;
      rand_stall = 1'b1;
      mptr       = 0;
      repeat (2) begin
         for (int i = 0; i < N; i++)
            repeat ($urandom_range(1, 3))
               push_pkt(i, $urandom_range(1, 20), 8'($urandom), 1'b0);
         for (int i = 0; i < N; i++) mq[i] = rq[i];
         more = 1'b1;
         while (more) begin
            sel = -1;
            for (int k = 0; k < N; k++) begin
               idx = (mptr + k) % N;
               if (sel < 0 && mq[idx].size() > 0) sel = idx;
            end
            if (sel < 0) begin
               more = 1'b0;
            end else begin
               cnt = 0;
               do begin
                  b = mq[sel].pop_front();
                  push_exp(sel, b.data);
                  cnt++;
               end while (!b.last && cnt < MB);
               mptr = (sel + 1) % N;
            end
         end
         wait_quiet("random_quiet", 20000);
      end
      rand_busy  = 1'b0;
      rand_stall = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
